// File: rtl/seq_match_pkg.sv
// ============================================================================
// Module  : seq_match_pkg
// Brief   : Shared FSM state type and default constants for seq_match_detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_match_pkg;

  localparam int DEF_PAT_WIDTH   = 4;
  localparam int DEF_COUNT_WIDTH = 8;
  localparam logic [DEF_PAT_WIDTH-1:0] DEF_PATTERN = 4'b1101;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear wins over inc).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/seq_match_detector.sv
// ============================================================================
// Module  : seq_match_detector
// Brief   : Serial pattern matcher with Mealy match pulse, loadable pattern,
//           overlap control and optional saturating match counter.
// Config  : define SEQ_MATCH_COUNT_EN to build the match counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_detector
  import seq_match_pkg::*;
#(
  parameter int                   PAT_WIDTH     = DEF_PAT_WIDTH,
  parameter int                   COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter logic [PAT_WIDTH-1:0] RESET_PATTERN = PAT_WIDTH'(DEF_PATTERN)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   en,
  input  logic                   i,
  input  logic                   overlap,
  input  logic                   pat_load,
  input  logic [PAT_WIDTH-1:0]   pat_in,
  input  logic                   clr_count,
  output logic                   o,
  output logic                   armed,
  output logic [COUNT_WIDTH-1:0] match_count
);

  localparam int                FILL_W    = $clog2(PAT_WIDTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_WIDTH - 1);

  state_e               state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [PAT_WIDTH-2:0] hist_q, hist_d;
  logic [PAT_WIDTH-1:0] pat_q, pat_d;
  logic [PAT_WIDTH-1:0] w_window;
  logic                 w_hit;

  assign w_window = {hist_q, i};

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    w_hit   = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = FILL;
    end else if (en) begin
      w_hit  = (state_q == ARMED) && (w_window == pat_q);
      hist_d = w_window[PAT_WIDTH-2:0];
      // Non-overlapping mode restarts the fill so no bit of this match is reused.
      if (w_hit && !overlap) begin
        fill_d  = '0;
        state_d = FILL;
      end else begin
        if (fill_q != FILL_LAST) begin
          fill_d = fill_q + 1'b1;
        end
        state_d = (fill_d == FILL_LAST) ? ARMED : FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= RESET_PATTERN;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end

  assign o     = w_hit & n_rst;
  assign armed = (state_q == ARMED);

`ifdef SEQ_MATCH_COUNT_EN
  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_match_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clr_count),
    .inc   (o),
    .count (match_count)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_count;
  assign match_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_match_detector.sv
// ============================================================================
// Module  : tb_seq_match_detector
// Brief   : Directed self-checking bench for seq_match_detector (counter
//           expectations follow SEQ_MATCH_COUNT_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_match_detector;

`ifdef SEQ_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b0;
  logic       i = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_count = 1'b0;

  logic       o1, armed1;
  logic [7:0] cnt1;
  logic       o2, armed2;
  logic [1:0] cnt2;

  logic       o_s;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  seq_match_detector u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .i           (i),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .clr_count   (clr_count),
    .o           (o1),
    .armed       (armed1),
    .match_count (cnt1)
  );

  seq_match_detector #(
    .COUNT_WIDTH (2)
  ) u_dut_w2 (
    .clk         (clk),
    .n_rst       (n_rst),
    .en          (en),
    .i           (i),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .clr_count   (clr_count),
    .o           (o2),
    .armed       (armed2),
    .match_count (cnt2)
  );

  // One clock: drive at negedge, capture the Mealy output, return just after posedge.
  task automatic cyc(input logic e, input logic b);
    @(negedge clk);
    en = e;
    i  = b;
    #1;
    o_s = o1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; pat_load = 1'b0; clr_count = 1'b0; overlap = 1'b1;
    cyc(1'b0, 1'b0);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (armed1 !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed1); end
    checks++;
    if (cnt1 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
  endtask

  task automatic test_overlap();
    logic [6:0] stim = 7'b1101101;
    logic [6:0] expo = 7'b0001001;
    do_reset();
    overlap = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, stim[6-k]);
      checks++;
      if (o_s !== expo[6-k]) begin
        failures++; $display("FAIL overlap_o[%0d] got=%b exp=%b", k, o_s, expo[6-k]);
      end
      if (k == 2) begin
        checks++;
        if (armed1 !== 1'b1) begin failures++; $display("FAIL overlap_armed got=%b exp=1", armed1); end
      end
    end
    checks++;
    if (cnt1 !== (CNT_EN ? 8'd2 : 8'd0)) begin
      failures++; $display("FAIL overlap_count got=%0d exp=%0d", cnt1, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] stim  = 7'b1101101;
    logic [6:0] expo  = 7'b0001000;
    logic [6:0] exparm = 7'b0010001;
    do_reset();
    overlap = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, stim[6-k]);
      checks++;
      if (o_s !== expo[6-k]) begin
        failures++; $display("FAIL nonovl_o[%0d] got=%b exp=%b", k, o_s, expo[6-k]);
      end
      checks++;
      if (armed1 !== exparm[6-k]) begin
        failures++; $display("FAIL nonovl_armed[%0d] got=%b exp=%b", k, armed1, exparm[6-k]);
      end
    end
    checks++;
    if (cnt1 !== (CNT_EN ? 8'd1 : 8'd0)) begin
      failures++; $display("FAIL nonovl_count got=%0d exp=%0d", cnt1, CNT_EN ? 1 : 0);
    end
    overlap = 1'b1;
  endtask

  task automatic test_pat_load();
    logic [3:0] stim = 4'b0110;
    logic [3:0] expo = 4'b0001;
    do_reset();
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    checks++;
    if (armed1 !== 1'b1) begin failures++; $display("FAIL load_pre_armed got=%b exp=1", armed1); end
    pat_load = 1'b1; pat_in = 4'b0110;
    cyc(1'b1, 1'b1);
    pat_load = 1'b0;
    checks++;
    if (o_s !== 1'b0) begin failures++; $display("FAIL load_o got=%b exp=0", o_s); end
    checks++;
    if (armed1 !== 1'b0) begin failures++; $display("FAIL load_armed got=%b exp=0", armed1); end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, stim[3-k]);
      checks++;
      if (o_s !== expo[3-k]) begin
        failures++; $display("FAIL load_o[%0d] got=%b exp=%b", k, o_s, expo[3-k]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] e2;
    do_reset();
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    for (int m = 1; m <= 5; m++) begin
      if (m > 1) begin
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
      end
      cyc(1'b1, 1'b1);
      e2 = CNT_EN ? ((m > 3) ? 2'd3 : 2'(m)) : 2'd0;
      checks++;
      if (o_s !== 1'b1) begin failures++; $display("FAIL sat_o[%0d] got=%b exp=1", m, o_s); end
      checks++;
      if (cnt2 !== e2) begin failures++; $display("FAIL sat_cnt2[%0d] got=%0d exp=%0d", m, cnt2, e2); end
      checks++;
      if (cnt1 !== (CNT_EN ? 8'(m) : 8'd0)) begin
        failures++; $display("FAIL sat_cnt8[%0d] got=%0d exp=%0d", m, cnt1, CNT_EN ? m : 0);
      end
    end
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    clr_count = 1'b1;
    cyc(1'b1, 1'b1);
    clr_count = 1'b0;
    checks++;
    if (o_s !== 1'b1) begin failures++; $display("FAIL clr_o got=%b exp=1", o_s); end
    checks++;
    if (cnt2 !== 2'd0) begin failures++; $display("FAIL clr_cnt2 got=%0d exp=0", cnt2); end
    checks++;
    if (cnt1 !== 8'd0) begin failures++; $display("FAIL clr_cnt8 got=%0d exp=0", cnt1); end
  endtask

  task automatic test_en_gap();
    logic [6:0] ev   = 7'b1010101;
    logic [6:0] stim = 7'b1011001;
    logic [6:0] expo = 7'b0000001;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(ev[6-k], stim[6-k]);
      checks++;
      if (o_s !== expo[6-k]) begin
        failures++; $display("FAIL engap_o[%0d] got=%b exp=%b", k, o_s, expo[6-k]);
      end
    end
    do_reset();
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    n_rst = 1'b0;
    cyc(1'b1, 1'b1);
    n_rst = 1'b1;
    checks++;
    if (o_s !== 1'b0) begin failures++; $display("FAIL midrst_o got=%b exp=0", o_s); end
    checks++;
    if (armed1 !== 1'b0) begin failures++; $display("FAIL midrst_armed got=%b exp=0", armed1); end
    cyc(1'b1, 1'b1);
    checks++;
    if (o_s !== 1'b0) begin failures++; $display("FAIL midrst_first_o got=%b exp=0", o_s); end
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    checks++;
    if (armed1 !== 1'b1) begin failures++; $display("FAIL midrst_rearm got=%b exp=1", armed1); end
    cyc(1'b1, 1'b1);
    checks++;
    if (o_s !== 1'b1) begin failures++; $display("FAIL midrst_match got=%b exp=1", o_s); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_pat_load();
    test_saturate();
    test_en_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
